// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, runs one ibus read at a time,
// and hands {pc, instr} to decode, dropping responses made stale by redirects.
module fetch_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(32'hbfc0_0000)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  stall,
  output logic                  ireq_valid,
  output logic [ADDR_WIDTH-1:0] ireq_addr,
  input  logic                  ireq_addr_ok,
  input  logic                  iresp_data_ok,
  input  logic [ADDR_WIDTH-1:0] iresp_data,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [ADDR_WIDTH-1:0] out_instr,
  output logic                  out_adel,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                state, n_state;
  logic [ADDR_WIDTH-1:0] pc, n_pc;
  logic [ADDR_WIDTH-1:0] n_ireq_addr;
  logic [ADDR_WIDTH-1:0] n_out_pc, n_out_instr;
  logic                  n_ireq_valid, n_out_valid;
  logic                  n_out_adel, drop, n_drop;
  logic                  do_start, do_capture;
  logic [ADDR_WIDTH-1:0] start_addr;

  assign busy = (state == REQ) || (state == WAIT);

  always_comb begin
    n_state      = state;
    n_pc         = pc;
    n_ireq_valid = ireq_valid;
    n_ireq_addr  = ireq_addr;
    n_out_valid  = out_valid;
    n_out_pc     = out_pc;
    n_out_instr  = out_instr;
    n_out_adel   = out_adel;
    n_drop       = drop;
    do_start     = 1'b0;
    do_capture   = 1'b0;
    start_addr   = pc;

    if (redirect_valid) begin
      n_pc        = redirect_pc;
      n_out_valid = 1'b0;
    end

    unique case (state)
      IDLE: begin
        do_start   = 1'b1;
        start_addr = redirect_valid ? redirect_pc : pc;
      end
      REQ, WAIT: begin
        if (iresp_data_ok && (state == WAIT || ireq_addr_ok)) begin
          if (redirect_valid) begin
            n_drop     = 1'b0;
            do_start   = 1'b1;
            start_addr = redirect_pc;
          end else if (drop) begin
            n_drop     = 1'b0;
            do_start   = 1'b1;
            start_addr = pc;
          end else begin
            do_capture = 1'b1;
          end
        end else begin
          if (redirect_valid) n_drop = 1'b1;
          if (state == REQ && ireq_addr_ok) begin
            n_state      = WAIT;
            n_ireq_valid = 1'b0;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          do_start   = 1'b1;
          start_addr = redirect_pc;
        end else if (out_valid && !stall) begin
          do_start   = 1'b1;
          start_addr = pc + ADDR_WIDTH'(4);
        end
      end
      default: n_state = IDLE;
    endcase

    if (do_capture) begin
      n_state      = HOLD;
      n_ireq_valid = 1'b0;
      n_out_valid  = 1'b1;
      n_out_adel   = 1'b0;
      n_out_pc     = ireq_addr;
      n_out_instr  = iresp_data;
    end

    // misaligned targets never reach the bus; they are delivered as an adel word
    if (do_start) begin
      n_pc = start_addr;
      if (start_addr[1:0] != 2'b00) begin
        n_state      = HOLD;
        n_ireq_valid = 1'b0;
        n_out_valid  = 1'b1;
        n_out_adel   = 1'b1;
        n_out_pc     = start_addr;
        n_out_instr  = '0;
      end else begin
        n_state      = REQ;
        n_ireq_valid = 1'b1;
        n_ireq_addr  = start_addr;
        n_out_valid  = 1'b0;
        n_out_adel   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ireq_valid <= 1'b0;
      ireq_addr  <= '0;
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_instr  <= '0;
      out_adel   <= 1'b0;
      drop       <= 1'b0;
    end else begin
      state      <= n_state;
      pc         <= n_pc;
      ireq_valid <= n_ireq_valid;
      ireq_addr  <= n_ireq_addr;
      out_valid  <= n_out_valid;
      out_pc     <= n_out_pc;
      out_instr  <= n_out_instr;
      out_adel   <= n_out_adel;
      drop       <= n_drop;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: per-cycle vector table
// plus hand-written async reset sequences.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_adel;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .ireq_addr_ok  (ireq_addr_ok),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_adel      (out_adel),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rv;
    logic [31:0] rpc;
    logic        st;
    logic        aok;
    logic        dok;
    logic [31:0] d;
    logic        iv;
    logic [31:0] ia;
    logic        ov;
    logic [31:0] opc;
    logic [31:0] oin;
    logic        adel;
    logic        bsy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic rv, input logic [31:0] rpc,
    input logic st, input logic aok,
    input logic dok, input logic [31:0] d,
    input logic iv, input logic [31:0] ia,
    input logic ov, input logic [31:0] opc,
    input logic [31:0] oin, input logic adel,
    input logic bsy);
    vec_t r;
    r.rv = rv; r.rpc = rpc; r.st = st;
    r.aok = aok; r.dok = dok; r.d = d;
    r.iv = iv; r.ia = ia; r.ov = ov;
    r.opc = opc; r.oin = oin;
    r.adel = adel; r.bsy = bsy;
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               name, got, exp);
    end
  endtask

  task automatic chk_vec(input int i, input vec_t e);
    logic [130:0] got, exp;
    got = {ireq_valid, ireq_addr, out_valid,
           out_pc, out_instr, out_adel, busy};
    exp = {e.iv, e.ia, e.ov, e.opc,
           e.oin, e.adel, e.bsy};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL row%0d: got iv=%b ia=%h ov=%b pc=%h in=%h adel=%b busy=%b",
               i, ireq_valid, ireq_addr, out_valid,
               out_pc, out_instr, out_adel, busy);
      $display("     row%0d want iv=%b ia=%h ov=%b pc=%h in=%h adel=%b busy=%b",
               i, e.iv, e.ia, e.ov, e.opc,
               e.oin, e.adel, e.bsy);
    end
  endtask

  task automatic idle_in();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    ireq_addr_ok   = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset + basic delivery with late handshakes
    tbl.push_back(v(0,0,0,0,0,0, 1,32'hbfc00000,0,0,0,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 1,32'hbfc00000,0,0,0,0,1));
    tbl.push_back(v(0,0,0,1,0,0, 0,32'hbfc00000,0,0,0,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 0,32'hbfc00000,0,0,0,0,1));
    tbl.push_back(v(0,0,0,0,1,32'h11111111,
      0,32'hbfc00000,1,32'hbfc00000,32'h11111111,0,0));
    tbl.push_back(v(0,0,0,0,0,0,
      1,32'hbfc00004,0,32'hbfc00000,32'h11111111,0,1));
    // stall holds the word
    tbl.push_back(v(0,0,0,1,1,32'h22222222,
      0,32'hbfc00004,1,32'hbfc00004,32'h22222222,0,0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(v(0,0,1,0,0,0,
        0,32'hbfc00004,1,32'hbfc00004,32'h22222222,0,0));
    tbl.push_back(v(0,0,0,0,0,0,
      1,32'hbfc00008,0,32'hbfc00004,32'h22222222,0,1));
    // redirect in WAIT
    tbl.push_back(v(0,0,0,1,0,0,
      0,32'hbfc00008,0,32'hbfc00004,32'h22222222,0,1));
    tbl.push_back(v(1,32'h80001000,0,0,0,0,
      0,32'hbfc00008,0,32'hbfc00004,32'h22222222,0,1));
    tbl.push_back(v(0,0,0,0,1,32'h33333333,
      1,32'h80001000,0,32'hbfc00004,32'h22222222,0,1));
    tbl.push_back(v(0,0,0,1,1,32'h44444444,
      0,32'h80001000,1,32'h80001000,32'h44444444,0,0));
    // misaligned redirect over a stalled word
    tbl.push_back(v(1,32'h80000002,1,0,0,0,
      0,32'h80001000,1,32'h80000002,0,1,0));
    tbl.push_back(v(0,0,1,0,0,0,
      0,32'h80001000,1,32'h80000002,0,1,0));
    tbl.push_back(v(0,0,0,0,0,0,
      0,32'h80001000,1,32'h80000006,0,1,0));
    tbl.push_back(v(1,32'h80000010,0,0,0,0,
      1,32'h80000010,0,32'h80000006,0,0,1));
    tbl.push_back(v(0,0,0,1,1,32'h55555555,
      0,32'h80000010,1,32'h80000010,32'h55555555,0,0));
    tbl.push_back(v(0,0,0,0,0,0,
      1,32'h80000014,0,32'h80000010,32'h55555555,0,1));
    // redirect in REQ while address not accepted
    tbl.push_back(v(1,32'h80002000,0,0,0,0,
      1,32'h80000014,0,32'h80000010,32'h55555555,0,1));
    tbl.push_back(v(0,0,0,0,0,0,
      1,32'h80000014,0,32'h80000010,32'h55555555,0,1));
    tbl.push_back(v(0,0,0,1,0,0,
      0,32'h80000014,0,32'h80000010,32'h55555555,0,1));
    tbl.push_back(v(0,0,0,0,1,32'h66666666,
      1,32'h80002000,0,32'h80000010,32'h55555555,0,1));
    tbl.push_back(v(0,0,0,1,1,32'h77777777,
      0,32'h80002000,1,32'h80002000,32'h77777777,0,0));
    // back-to-back redirects while dropping
    tbl.push_back(v(0,0,0,0,0,0,
      1,32'h80002004,0,32'h80002000,32'h77777777,0,1));
    tbl.push_back(v(1,32'h80003000,0,1,0,0,
      0,32'h80002004,0,32'h80002000,32'h77777777,0,1));
    tbl.push_back(v(1,32'h80004000,0,0,0,0,
      0,32'h80002004,0,32'h80002000,32'h77777777,0,1));
    tbl.push_back(v(0,0,0,0,1,32'h88888888,
      1,32'h80004000,0,32'h80002000,32'h77777777,0,1));
    tbl.push_back(v(1,32'h80005000,0,1,1,32'h99999999,
      1,32'h80005000,0,32'h80002000,32'h77777777,0,1));
    tbl.push_back(v(0,0,0,1,1,32'haaaaaaaa,
      0,32'h80005000,1,32'h80005000,32'haaaaaaaa,0,0));
    // pc wrap
    tbl.push_back(v(1,32'hfffffffc,0,0,0,0,
      1,32'hfffffffc,0,32'h80005000,32'haaaaaaaa,0,1));
    tbl.push_back(v(0,0,0,1,1,32'hbbbbbbbb,
      0,32'hfffffffc,1,32'hfffffffc,32'hbbbbbbbb,0,0));
    tbl.push_back(v(0,0,0,0,0,0,
      1,32'h00000000,0,32'hfffffffc,32'hbbbbbbbb,0,1));
    tbl.push_back(v(0,0,0,1,0,0,
      0,32'h00000000,0,32'hfffffffc,32'hbbbbbbbb,0,1));

    idle_in();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ireq_valid", 32'(ireq_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_adel", 32'(out_adel), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i > 0) @(negedge clk);
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      stall          = tbl[i].st;
      ireq_addr_ok   = tbl[i].aok;
      iresp_data_ok  = tbl[i].dok;
      iresp_data     = tbl[i].d;
      step();
      chk_vec(i, tbl[i]);
    end

    // async reset during WAIT, stray response afterwards
    @(negedge clk);
    idle_in();
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hdeadbeef;
    resetn        = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ireq_valid", 32'(ireq_valid), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_pc", out_pc, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    chk("rf_ireq_valid", 32'(ireq_valid), 32'd1);
    chk("rf_ireq_addr", ireq_addr, 32'hbfc00000);
    chk("rf_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    idle_in();
    ireq_addr_ok = 1'b1;
    step();
    chk("rf_wait_busy", 32'(busy), 32'd1);
    @(negedge clk);
    idle_in();
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hcafef00d;
    step();
    chk("rf_out_valid2", 32'(out_valid), 32'd1);
    chk("rf_out_pc", out_pc, 32'hbfc00000);
    chk("rf_out_instr", out_instr, 32'hcafef00d);

    // async reset while a word is held
    @(negedge clk);
    idle_in();
    stall  = 1'b1;
    resetn = 1'b0;
    #1;
    chk("hrst_out_valid", 32'(out_valid), 32'd0);
    chk("hrst_out_instr", out_instr, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    stall  = 1'b0;
    step();
    chk("hrst_ireq_addr", ireq_addr, 32'hbfc00000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
